// File: rtl/washmachine_phase_timer_if.sv
// ---------------------------------------------------------------------------
// washmachine_phase_timer_if
// Link between the washer control FSM (master) and the phase timer (slave).
//   state_in      : 3-bit Gray-coded FSM state, FSM -> timer
//   wash_done     : wash time up, timer -> FSM
//   water_done    : drain time up, timer -> FSM
//   dewater_done  : spin time up, timer -> FSM
//   alarm_done    : alarm time up, timer -> FSM
//   remain        : seconds left in the current timed phase, timer -> display
//   pause_n       : active-low pause switch (only with PHASE_TIMER_PAUSE_EN)
// Optional feature macro: PHASE_TIMER_PAUSE_EN adds pause_n.
// ---------------------------------------------------------------------------
interface washmachine_phase_timer_if;
    logic [2:0] state_in;
    logic       wash_done;
    logic       water_done;
    logic       dewater_done;
    logic       alarm_done;
    logic [7:0] remain;
`ifdef PHASE_TIMER_PAUSE_EN
    logic       pause_n;

    modport master (
        output state_in, pause_n,
        input  wash_done, water_done, dewater_done, alarm_done, remain
    );
    modport slave (
        input  state_in, pause_n,
        output wash_done, water_done, dewater_done, alarm_done, remain
    );
`else
    modport master (
        output state_in,
        input  wash_done, water_done, dewater_done, alarm_done, remain
    );
    modport slave (
        input  state_in,
        output wash_done, water_done, dewater_done, alarm_done, remain
    );
`endif
endinterface

// File: rtl/washmachine_phase_timer.sv
// ---------------------------------------------------------------------------
// washmachine_phase_timer
// Times the wash, drain, spin and alarm phases of the washer control FSM and
// returns level "time up" flags plus the remaining seconds of the phase.
// Ports:
//   clk    : system clock
//   reset  : synchronous active-low reset
//   bus    : washmachine_phase_timer_if.slave (state_in in; *_done, remain out;
//            pause_n in when PHASE_TIMER_PAUSE_EN is defined)
// Optional feature macro: PHASE_TIMER_PAUSE_EN (pause_n freezes the count).
// ---------------------------------------------------------------------------
module washmachine_phase_timer #(
    parameter int CLK_DIV     = 50000000,
    parameter int WASH_SEC    = 10,
    parameter int WATER_SEC   = 5,
    parameter int DEWATER_SEC = 8,
    parameter int ALARM_SEC   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    washmachine_phase_timer_if.slave  bus
);

    localparam int             PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]  PRESC_ZERO = PW'(0);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);

    localparam logic [2:0] ST_WASH    = 3'b011;
    localparam logic [2:0] ST_WATER   = 3'b010;
    localparam logic [2:0] ST_DEWATER = 3'b110;
    localparam logic [2:0] ST_ALARM   = 3'b100;

    // Duration in seconds loaded on entry; untimed codes load zero.
    function automatic logic [7:0] phase_duration(input logic [2:0] code);
        logic [7:0] d;
        case (code)
            ST_WASH:    d = 8'(WASH_SEC);
            ST_WATER:   d = 8'(WATER_SEC);
            ST_DEWATER: d = 8'(DEWATER_SEC);
            ST_ALARM:   d = 8'(ALARM_SEC);
            default:    d = 8'd0;
        endcase
        return d;
    endfunction

    // One-hot done flag owned by a state: {alarm, dewater, water, wash}.
    function automatic logic [3:0] phase_flag(input logic [2:0] code);
        logic [3:0] f;
        case (code)
            ST_WASH:    f = 4'b0001;
            ST_WATER:   f = 4'b0010;
            ST_DEWATER: f = 4'b0100;
            ST_ALARM:   f = 4'b1000;
            default:    f = 4'b0000;
        endcase
        return f;
    endfunction

    logic [2:0]    state_r;
    logic [PW-1:0] presc_r;
    logic [7:0]    remain_r;
    logic [3:0]    done_r;

    logic          phase_change_s;
    logic          timed_s;
    logic          tick_s;
    logic          run_s;

    assign phase_change_s = (bus.state_in != state_r);
    assign timed_s        = |phase_flag(state_r);
    assign tick_s         = (presc_r == PRESC_LAST);

`ifdef PHASE_TIMER_PAUSE_EN
    assign run_s = bus.pause_n;
`else
    assign run_s = 1'b1;
`endif

    // Phase tracking, one-second prescaler, countdown and done flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= 3'b000;
            presc_r  <= PRESC_ZERO;
            remain_r <= 8'd0;
            done_r   <= 4'b0000;
        end else begin
            state_r <= bus.state_in;
            if (phase_change_s) begin
                // Entry always restarts from the full duration; nothing carries over.
                presc_r  <= PRESC_ZERO;
                remain_r <= phase_duration(bus.state_in);
                done_r   <= 4'b0000;
            end else if (!timed_s) begin
                presc_r  <= PRESC_ZERO;
                remain_r <= 8'd0;
                done_r   <= 4'b0000;
            end else if (!run_s) begin
                // Paused: freeze everything, existing flag holds.
                presc_r  <= presc_r;
                remain_r <= remain_r;
                done_r   <= done_r;
            end else if (remain_r == 8'd0) begin
                // Expired (or zero-length phase): raise and hold the flag.
                presc_r  <= presc_r;
                remain_r <= 8'd0;
                done_r   <= done_r | phase_flag(state_r);
            end else if (tick_s) begin
                presc_r  <= PRESC_ZERO;
                remain_r <= remain_r - 8'd1;
                if (remain_r == 8'd1) begin
                    done_r <= done_r | phase_flag(state_r);
                end else begin
                    done_r <= done_r;
                end
            end else begin
                presc_r  <= presc_r + PRESC_ONE;
                remain_r <= remain_r;
                done_r   <= done_r;
            end
        end
    end

    assign bus.wash_done    = done_r[0];
    assign bus.water_done   = done_r[1];
    assign bus.dewater_done = done_r[2];
    assign bus.alarm_done   = done_r[3];
    assign bus.remain       = remain_r;

endmodule

// File: tb/tb_washmachine_phase_timer.sv
module tb_washmachine_phase_timer;

    localparam int CDIV = 4;

    logic       clk = 1'b0;
    logic       reset_v = 1'b0;
    logic [2:0] state_v = 3'b000;
    logic       pause_v = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    washmachine_phase_timer_if if_a();
    washmachine_phase_timer_if if_b();

    assign if_a.state_in = state_v;
    assign if_b.state_in = state_v;
`ifdef PHASE_TIMER_PAUSE_EN
    assign if_a.pause_n = pause_v;
    assign if_b.pause_n = pause_v;
`endif

    // dut_a: WATER_SEC=2, dut_b: WATER_SEC=0 (zero-length drain phase)
    washmachine_phase_timer #(.CLK_DIV(CDIV), .WASH_SEC(3), .WATER_SEC(2),
                              .DEWATER_SEC(1), .ALARM_SEC(1))
        dut_a (.clk(clk), .reset(reset_v), .bus(if_a));
    washmachine_phase_timer #(.CLK_DIV(CDIV), .WASH_SEC(3), .WATER_SEC(0),
                              .DEWATER_SEC(1), .ALARM_SEC(1))
        dut_b (.clk(clk), .reset(reset_v), .bus(if_b));

    wire [3:0] fl_a = {if_a.alarm_done, if_a.dewater_done, if_a.water_done, if_a.wash_done};
    wire [3:0] fl_b = {if_b.alarm_done, if_b.dewater_done, if_b.water_done, if_b.wash_done};

    // Reference model: current phase and number of running edges since entry.
    logic [2:0] m_phase = 3'b000;
    int         m_run   = 0;

    function automatic int dur(input logic [2:0] c, input int water);
        case (c)
            3'b011:  return 3;
            3'b010:  return water;
            3'b110:  return 1;
            3'b100:  return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] fmask(input logic [2:0] c);
        case (c)
            3'b011:  return 4'b0001;
            3'b010:  return 4'b0010;
            3'b110:  return 4'b0100;
            3'b100:  return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_edge();
        logic run_en;
`ifdef PHASE_TIMER_PAUSE_EN
        run_en = pause_v;
`else
        run_en = 1'b1;
`endif
        if (!reset_v) begin
            m_phase = 3'b000;
            m_run   = 0;
        end else if (state_v != m_phase) begin
            m_phase = state_v;
            m_run   = 0;
        end else if (run_en && m_run < 100000) begin
            m_run++;
        end
    endtask

    task automatic check_inst(input string tag, input logic [7:0] rem,
                              input logic [3:0] fl, input int water);
        int         d;
        logic [7:0] exp_rem;
        logic [3:0] exp_fl;
        d = dur(m_phase, water);
        if (d == 0 || (m_run / CDIV) >= d) exp_rem = 8'd0;
        else                               exp_rem = 8'(d - m_run / CDIV);
        if ((d == 0 && m_run >= 1) || (d > 0 && m_run >= d * CDIV)) exp_fl = fmask(m_phase);
        else                                                        exp_fl = 4'b0000;
        checks++;
        assert (rem === exp_rem) else begin
            errors++;
            $error("FAIL model_remain_%s: got %0d expected %0d", tag, rem, exp_rem);
        end
        checks++;
        assert (fl === exp_fl) else begin
            errors++;
            $error("FAIL model_flags_%s: got %b expected %b", tag, fl, exp_fl);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic [2:0] st, input logic rn, input logic pn);
        state_v = st;
        reset_v = rn;
        pause_v = pn;
        @(posedge clk);
        model_edge();
        #1;
        check_inst("a", if_a.remain, fl_a, 2);
        check_inst("b", if_b.remain, fl_b, 0);
    endtask

    // Step in the current state until dut_a raises flag idx; n counts edges since entry.
    task automatic wait_a(input int idx, input int start, input int exp_n, input string tag);
        int n;
        n = start;
        while (fl_a[idx] !== 1'b1 && n < 200) begin
            step(state_v, 1'b1, 1'b1);
            n++;
        end
        chk(tag, n, exp_n);
    endtask

    initial begin
        // 1: reset, then idle -> supply -> wash
        step(3'b000, 1'b0, 1'b1);
        step(3'b000, 1'b0, 1'b1);
        chk("reset_remain", if_a.remain, 0);
        chk("reset_flags", fl_a, 0);
        step(3'b001, 1'b1, 1'b1);
        step(3'b011, 1'b1, 1'b1);
        chk("wash_entry_remain", if_a.remain, 3);
        repeat (4) step(3'b011, 1'b1, 1'b1);
        chk("wash_e4_remain", if_a.remain, 2);
        repeat (4) step(3'b011, 1'b1, 1'b1);
        chk("wash_e8_remain", if_a.remain, 1);
        repeat (3) step(3'b011, 1'b1, 1'b1);
        chk("wash_e11_flag", if_a.wash_done, 0);
        step(3'b011, 1'b1, 1'b1);
        chk("wash_e12_remain", if_a.remain, 0);
        chk("wash_e12_flag", fl_a, 4'b0001);
        repeat (2) step(3'b011, 1'b1, 1'b1);
        chk("wash_hold_flag", fl_a, 4'b0001);

        // 2 and 4: full cycle water -> dewater -> alarm -> idle
        step(3'b010, 1'b1, 1'b1);
        chk("water_entry_wash_clr", if_a.wash_done, 0);
        chk("water_entry_remain", if_a.remain, 2);
        chk("b_water_entry_flag", if_b.water_done, 0);
        step(3'b010, 1'b1, 1'b1);
        chk("b_water_e1_flag", if_b.water_done, 1);
        chk("b_water_e1_remain", if_b.remain, 0);
        wait_a(1, 1, 8, "water_latency");
        step(3'b110, 1'b1, 1'b1);
        chk("dewater_entry_water_clr", if_a.water_done, 0);
        wait_a(2, 0, 4, "dewater_latency");
        step(3'b100, 1'b1, 1'b1);
        wait_a(3, 0, 4, "alarm_latency");
        step(3'b000, 1'b1, 1'b1);
        chk("idle_alarm_clr", fl_a, 0);

        // 3: abort mid-wash and re-enter
        step(3'b011, 1'b1, 1'b1);
        repeat (4) step(3'b011, 1'b1, 1'b1);
        chk("abort_pre_remain", if_a.remain, 2);
        step(3'b000, 1'b1, 1'b1);
        chk("abort_remain", if_a.remain, 0);
        chk("abort_flag", if_a.wash_done, 0);
        step(3'b011, 1'b1, 1'b1);
        chk("reenter_remain", if_a.remain, 3);
        wait_a(0, 0, 12, "reenter_latency");

        // 5: reset during dewater
        step(3'b110, 1'b1, 1'b1);
        chk("dw_entry_remain", if_a.remain, 1);
        step(3'b110, 1'b0, 1'b1);
        chk("midreset_remain", if_a.remain, 0);
        chk("midreset_flags", fl_a, 0);
        step(3'b110, 1'b1, 1'b1);
        chk("postreset_remain", if_a.remain, 1);
        wait_a(2, 0, 4, "postreset_latency");

`ifdef PHASE_TIMER_PAUSE_EN
        // 6: pause 10 cycles at remain=2
        step(3'b000, 1'b1, 1'b1);
        step(3'b011, 1'b1, 1'b1);
        repeat (4) step(3'b011, 1'b1, 1'b1);
        chk("pause_pre_remain", if_a.remain, 2);
        repeat (10) step(3'b011, 1'b1, 1'b0);
        chk("pause_remain", if_a.remain, 2);
        chk("pause_flag", if_a.wash_done, 0);
        wait_a(0, 14, 22, "pause_latency");
`endif

        // Randomized phase sequence against the model
        for (int i = 0; i < 400; i++) begin
            logic [2:0] st;
            logic       rn;
            logic       pn;
            st = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : state_v;
            rn = ($urandom_range(0, 59) != 0);
            pn = ($urandom_range(0, 4) != 0);
            step(st, rn, pn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
